// File: rtl/pc_fetch_seq.sv
// Program-counter sequencer for the fetch stage.
// Holds the current PC and advances it by STEP when decode accepts it.
// It takes redirects from branches and jumps, and presents the PC to decode
// with a valid/ready handshake.
// A misaligned redirect target traps the block into a sticky FAULT state.
// Only reset leaves FAULT.
module pc_fetch_seq #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      STEP     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             out_valid,
  output logic             fault,
  output logic [WIDTH-1:0] fault_pc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // STEP is a power of two, so the low bits of the target must be zero.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_value_next;
  logic             fault_reg, fault_next;
  logic [WIDTH-1:0] fault_pc_reg, fault_pc_next;
  logic             misaligned;
  logic             handshake;

  assign misaligned = |(target & ALIGN_MASK);
  assign handshake  = en & out_ready;

  // The sequential successor wraps mod 2^WIDTH and has no carry out.
  assign pc_next   = pc_reg + STEP_W;
  assign pc        = pc_reg;
  assign out_valid = (state_reg == RUN);
  assign fault     = fault_reg;
  assign fault_pc  = fault_pc_reg;

  // Next-state and next-PC selection.
  // The priority order is: misaligned redirect, redirect, handshake, hold.
  always_comb begin
    state_next    = state_reg;
    pc_value_next = pc_reg;
    fault_next    = fault_reg;
    fault_pc_next = fault_pc_reg;
    case (state_reg)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (redirect && misaligned) begin
          state_next    = FAULT;
          fault_next    = 1'b1;
          fault_pc_next = target;
        end else if (redirect) begin
          // A redirect is a flush, so it ignores a stall or a cleared enable.
          pc_value_next = target;
        end else if (handshake) begin
          pc_value_next = pc_next;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // State and PC registers.
  // The synchronous reset has priority over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_PC;
      fault_reg    <= 1'b0;
      fault_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_value_next;
      fault_reg    <= fault_next;
      fault_pc_reg <= fault_pc_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq.
// Two instances share their stimulus: one resets to 0, the other to 0xFFFF_FFFC.
// A behavioural model predicts both instances and is compared on every falling edge.
// Literal expectations pin key points of the directed sequence.
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        redirect;
  logic [31:0] target;
  logic        out_ready;

  logic [31:0] pc_a, pc_next_a, fault_pc_a;
  logic        out_valid_a, fault_a;
  logic [31:0] pc_b, pc_next_b, fault_pc_b;
  logic        out_valid_b, fault_b;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_seq #(.WIDTH(32), .RESET_PC(32'h0000_0000), .STEP(4)) dut_a (
    .clk(clk), .reset(reset), .en(en), .redirect(redirect), .target(target),
    .out_ready(out_ready), .pc(pc_a), .pc_next(pc_next_a), .out_valid(out_valid_a),
    .fault(fault_a), .fault_pc(fault_pc_a)
  );

  pc_fetch_seq #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .STEP(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .redirect(redirect), .target(target),
    .out_ready(out_ready), .pc(pc_b), .pc_next(pc_next_b), .out_valid(out_valid_b),
    .fault(fault_b), .fault_pc(fault_pc_b)
  );

  // Behavioural model. phase 0 is waiting out the boot cycle.
  // Phase 1 is presenting PCs. Phase 2 is trapped.
  typedef struct {
    int          phase;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] fault_pc;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_step(model_t m, logic rst, logic en_i, logic redir,
                                        logic [31:0] tgt, logic rdy, logic [31:0] rpc);
    model_t r = m;
    if (rst) begin
      r.phase = 0; r.pc = rpc; r.fault = 1'b0; r.fault_pc = 32'd0;
    end else if (m.phase == 0) begin
      r.phase = 1;
    end else if (m.phase == 1) begin
      if (redir && (tgt % 4 != 0)) begin
        r.phase = 2; r.fault = 1'b1; r.fault_pc = tgt;
      end else if (redir) begin
        r.pc = tgt;
      end else if (en_i && rdy) begin
        r.pc = m.pc + 32'd4;
      end
    end
    return r;
  endfunction

  // Advance the model on every rising edge with the inputs the DUT sees.
  always @(posedge clk) begin
    ma <= model_step(ma, reset, en, redirect, target, out_ready, 32'h0000_0000);
    mb <= model_step(mb, reset, en, redirect, target, out_ready, 32'hFFFF_FFFC);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the model on every falling edge.
  always @(negedge clk) begin
    if (checking) begin
      check("a.pc",        pc_a,               ma.pc);
      check("a.pc_next",   pc_next_a,          ma.pc + 32'd4);
      check("a.out_valid", 32'(out_valid_a),   32'(ma.phase == 1));
      check("a.fault",     32'(fault_a),       32'(ma.fault));
      check("a.fault_pc",  fault_pc_a,         ma.fault_pc);
      check("b.pc",        pc_b,               mb.pc);
      check("b.pc_next",   pc_next_b,          mb.pc + 32'd4);
      check("b.out_valid", 32'(out_valid_b),   32'(mb.phase == 1));
      check("b.fault",     32'(fault_b),       32'(mb.fault));
      check("b.fault_pc",  fault_pc_b,         mb.fault_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b en=%0b rdy=%0b redir=%0b tgt=%h | a: pc=%h v=%0b f=%0b fpc=%h | b: pc=%h v=%0b",
             $time, reset, en, out_ready, redirect, target,
             pc_a, out_valid_a, fault_a, fault_pc_a, pc_b, out_valid_b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; en = 1'b0; redirect = 1'b0; target = 32'd0; out_ready = 1'b0;
    tick(); tick();
    checking = 1'b1;

    // 1. The boot cycle shows pc=RESET_PC with out_valid low.
    reset = 1'b0;
    check("t1 boot valid", 32'(out_valid_a), 32'd0);
    check("t1 boot pc",    pc_a,             32'h0);
    check("t1 boot fault", 32'(fault_a),     32'd0);
    check("t6 boot pc b",  pc_b,             32'hFFFF_FFFC);
    tick();
    check("t1 run valid", 32'(out_valid_a), 32'd1);
    check("t1 run pc",    pc_a,             32'h0);

    // 2. Sequential advance: 0, 4, 8.
    en = 1'b1; out_ready = 1'b1;
    check("t2 pc_next0", pc_next_a, 32'h4);
    tick(); check("t2 pc4", pc_a, 32'h4);
    tick(); check("t2 pc8", pc_a, 32'h8);
    check("t2 pc_next8", pc_next_a, 32'hC);

    // 3. A stall holds pc=8 with out_valid high.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3 stall pc",    pc_a,             32'h8);
      check("t3 stall valid", 32'(out_valid_a), 32'd1);
    end
    out_ready = 1'b1;
    tick(); check("t3 resume pc12", pc_a, 32'hC);

    // 4. A redirect overrides the stall. The target is presented after one edge.
    out_ready = 1'b0; redirect = 1'b1; target = 32'h100;
    tick(); check("t4 redirect pc", pc_a, 32'h100);
    redirect = 1'b0;
    tick(); check("t4 stalled pc", pc_a, 32'h100);
    out_ready = 1'b1;
    tick(); check("t4 pc104", pc_a, 32'h104);

    // A redirect coinciding with a handshake wins.
    redirect = 1'b1; target = 32'h40;
    tick(); check("redir+hs pc", pc_a, 32'h40);
    // With en low, the PC holds even though decode is ready.
    redirect = 1'b0; en = 1'b0;
    tick(); check("en0 hold pc", pc_a, 32'h40);
    en = 1'b1;

    // 5. A misaligned target traps. Later redirects are ignored.
    redirect = 1'b1; target = 32'h102;
    tick();
    check("t5 fault",    32'(fault_a),     32'd1);
    check("t5 fault_pc", fault_pc_a,       32'h102);
    check("t5 valid",    32'(out_valid_a), 32'd0);
    check("t5 pc held",  pc_a,             32'h40);
    for (int i = 0; i < 5; i++) begin
      target = (i % 2 == 0) ? 32'h200 : 32'h301;
      tick();
      check("t5 sticky fault",    32'(fault_a), 32'd1);
      check("t5 sticky fault_pc", fault_pc_a,   32'h102);
      check("t5 frozen pc",       pc_a,         32'h40);
    end
    redirect = 1'b0; reset = 1'b1;
    tick();
    check("t5 reset fault", 32'(fault_a),     32'd0);
    check("t5 reset pc",    pc_a,             32'h0);
    check("t5 reset valid", 32'(out_valid_a), 32'd0);
    check("t5 reset fpc",   fault_pc_a,       32'h0);

    // 6. The instance with RESET_PC=0xFFFF_FFFC wraps to zero.
    reset = 1'b0;
    tick();
    check("t6 b pc",      pc_b,             32'hFFFF_FFFC);
    check("t6 b valid",   32'(out_valid_b), 32'd1);
    check("t6 b pc_next", pc_next_b,        32'h0);
    tick();
    check("t6 b wrap", pc_b, 32'h0);
    check("t6 a pc4",  pc_a, 32'h4);

    // Reset in the middle of a stall also takes priority.
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("stall reset pc", pc_a, 32'h0);
    reset = 1'b0;
    tick(); tick();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
